// File: rtl/elev_pkg.sv
// elev_pkg: shared constants, request encodings and FSM state type
// for the elevator scheduler (elev_scheduler, elev_req_table).
package elev_pkg;

  localparam int NUM_FLOORS_DEF = 8;
  localparam int FLOOR_W        = 3;

  localparam logic [1:0] REQ_IN   = 2'd0;
  localparam logic [1:0] REQ_UP   = 2'd1;
  localparam logic [1:0] REQ_DOWN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/elev_req_table.sv
// elev_req_table: pending request bitmaps (inside / hall up / hall down),
// set/clear update and above/below/here summaries around one floor.
// Ports: clk, reset; i_set_* new request; i_home_set forces inside-0;
//   i_clr_* clear at one floor; i_eval_floor reference floor;
//   o_pend_* bitmaps; o_above/o_below any bit strictly above/below;
//   o_here_* bits at the reference floor.
module elev_req_table
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_set_en,
  input  logic [FLOOR_W-1:0]    i_set_floor,
  input  logic [1:0]            i_set_type,
  input  logic                  i_home_set,
  input  logic                  i_clr_en,
  input  logic [FLOOR_W-1:0]    i_clr_floor,
  input  logic                  i_clr_in,
  input  logic                  i_clr_up,
  input  logic                  i_clr_down,
  input  logic [FLOOR_W-1:0]    i_eval_floor,
  output logic [NUM_FLOORS-1:0] o_pend_in,
  output logic [NUM_FLOORS-1:0] o_pend_up,
  output logic [NUM_FLOORS-1:0] o_pend_down,
  output logic                  o_above,
  output logic                  o_below,
  output logic                  o_here_in,
  output logic                  o_here_up,
  output logic                  o_here_down
);

  logic [NUM_FLOORS-1:0] r_in, r_up, r_down;
  logic [NUM_FLOORS-1:0] w_set_in, w_set_up, w_set_down;
  logic [NUM_FLOORS-1:0] w_clr_in, w_clr_up, w_clr_down;
  logic [NUM_FLOORS-1:0] w_any;

  always_comb begin
    w_set_in    = '0;
    w_set_up    = '0;
    w_set_down  = '0;
    w_clr_in    = '0;
    w_clr_up    = '0;
    w_clr_down  = '0;
    o_above     = 1'b0;
    o_below     = 1'b0;
    o_here_in   = 1'b0;
    o_here_up   = 1'b0;
    o_here_down = 1'b0;
    w_any       = r_in | r_up | r_down;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i_set_en && int'(i_set_floor) == i) begin
        unique case (1'b1)
          i_set_type == REQ_IN:   w_set_in[i]   = 1'b1;
          i_set_type == REQ_UP:   w_set_up[i]   = 1'b1;
          i_set_type == REQ_DOWN: w_set_down[i] = 1'b1;
          default: ;
        endcase
      end
      if (i_clr_en && int'(i_clr_floor) == i) begin
        w_clr_in[i]   = i_clr_in;
        w_clr_up[i]   = i_clr_up;
        w_clr_down[i] = i_clr_down;
      end
      if (i > int'(i_eval_floor))
        o_above = o_above | w_any[i];
      if (i < int'(i_eval_floor))
        o_below = o_below | w_any[i];
      if (i == int'(i_eval_floor)) begin
        o_here_in   = r_in[i];
        o_here_up   = r_up[i];
        o_here_down = r_down[i];
      end
    end
    if (i_home_set)
      w_set_in[0] = 1'b1;
  end

  // A set landing on a bit being cleared wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in   <= '0;
      r_up   <= '0;
      r_down <= '0;
    end else begin
      r_in   <= (r_in & ~w_clr_in) | w_set_in;
      r_up   <= (r_up & ~w_clr_up) | w_set_up;
      r_down <= (r_down & ~w_clr_down) | w_set_down;
    end
  end

  assign o_pend_in   = r_in;
  assign o_pend_up   = r_up;
  assign o_pend_down = r_down;

endmodule

// File: rtl/elev_scheduler.sv
// elev_scheduler: single-car collective elevator controller (IDLE/MOVE/DOOR).
// Ports: clk, reset (sync, high); req_valid/req_floor/req_type request strobe;
//   cur_floor, dir, moving, door_open, arrived; pend_in/up/down bitmaps.
// Option: define IDLE_RETURN_EN to send an idle car home to floor 0.
module elev_scheduler
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8,
  parameter int IDLE_TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [1:0]            req_type,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pend_in,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_down
);

  localparam int CNT_W =
    $clog2(max3(TRAVEL_CYCLES, DOOR_CYCLES, IDLE_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

  state_t             r_state;
  logic [FLOOR_W-1:0] r_floor;
  logic               r_dir;
  logic               r_moving;
  logic               r_door;
  logic               r_arrived;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_req_ok;
  logic               w_step;
  logic [FLOOR_W-1:0] w_next_floor;
  logic [FLOOR_W-1:0] w_eval;
  logic               w_above, w_below;
  logic               w_ahead, w_behind;
  logic               w_h_in, w_h_up, w_h_down;
  logic               w_serve, w_here, w_any;
  logic               w_reopen, w_set_en;
  logic               w_enter_door;
  logic               w_home;

  always_comb begin
    w_req_ok = 1'b0;
    if (req_valid && int'(req_floor) < NUM_FLOORS) begin
      unique case (1'b1)
        req_type == REQ_IN:   w_req_ok = 1'b1;
        req_type == REQ_UP:   w_req_ok = int'(req_floor) != NUM_FLOORS - 1;
        req_type == REQ_DOWN: w_req_ok = req_floor != '0;
        default:              w_req_ok = 1'b0;
      endcase
    end
  end

  // On the stepping cycle everything is judged at the floor being entered.
  assign w_step       = (r_state == ST_MOVE) && (r_cnt == TRAVEL_LAST);
  assign w_next_floor = r_dir ? r_floor + FLOOR_W'(1)
                              : r_floor - FLOOR_W'(1);
  assign w_eval       = w_step ? w_next_floor : r_floor;

  assign w_ahead  = r_dir ? w_above : w_below;
  assign w_behind = r_dir ? w_below : w_above;
  assign w_here   = w_h_in | w_h_up | w_h_down;
  assign w_any    = |{pend_in, pend_up, pend_down};
  assign w_serve  = w_h_in
                  | (r_dir ? w_h_up : w_h_down)
                  | ((r_dir ? w_h_down : w_h_up) & ~w_ahead);

  // A call the open door already answers just holds the door.
  assign w_reopen = (r_state == ST_DOOR) && w_req_ok
                  && (req_floor == r_floor)
                  && ((req_type == REQ_IN) || !w_ahead
                      || (r_dir ? (req_type == REQ_UP)
                                : (req_type == REQ_DOWN)));
  assign w_set_en = w_req_ok && !w_reopen;

  assign w_enter_door = ((r_state == ST_IDLE) && (w_serve || w_here))
                      || (w_step && w_serve);

`ifdef IDLE_RETURN_EN
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  logic [CNT_W-1:0] r_idle;
  logic             w_idle_cnt;

  assign w_idle_cnt = (r_state == ST_IDLE) && !w_any
                    && (r_floor != '0) && !req_valid;
  assign w_home     = w_idle_cnt && (r_idle == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (reset || !w_idle_cnt || w_home)
      r_idle <= '0;
    else
      r_idle <= r_idle + CNT_W'(1);
  end
`else
  assign w_home = 1'b0;
`endif

  elev_req_table #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_table (
    .clk          (clk),
    .reset        (reset),
    .i_set_en     (w_set_en),
    .i_set_floor  (req_floor),
    .i_set_type   (req_type),
    .i_home_set   (w_home),
    .i_clr_en     (w_enter_door),
    .i_clr_floor  (w_eval),
    .i_clr_in     (1'b1),
    .i_clr_up     (r_dir | ~w_ahead),
    .i_clr_down   (~r_dir | ~w_ahead),
    .i_eval_floor (w_eval),
    .o_pend_in    (pend_in),
    .o_pend_up    (pend_up),
    .o_pend_down  (pend_down),
    .o_above      (w_above),
    .o_below      (w_below),
    .o_here_in    (w_h_in),
    .o_here_up    (w_h_up),
    .o_here_down  (w_h_down)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_floor   <= '0;
      r_dir     <= 1'b1;
      r_moving  <= 1'b0;
      r_door    <= 1'b0;
      r_arrived <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_arrived <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_enter_door) begin
            r_state   <= ST_DOOR;
            r_door    <= 1'b1;
            r_arrived <= 1'b1;
            if (!w_ahead)
              r_dir <= ~r_dir;
          end else if (w_any) begin
            r_state  <= ST_MOVE;
            r_moving <= 1'b1;
            if (!w_ahead)
              r_dir <= ~r_dir;
          end
        end
        ST_MOVE: begin
          if (w_step) begin
            r_floor <= w_next_floor;
            r_cnt   <= '0;
            if (w_enter_door) begin
              r_state   <= ST_DOOR;
              r_moving  <= 1'b0;
              r_door    <= 1'b1;
              r_arrived <= 1'b1;
              if (!w_ahead)
                r_dir <= ~r_dir;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DOOR: begin
          if (w_reopen) begin
            r_cnt <= '0;
          end else if (r_cnt == DOOR_LAST) begin
            r_cnt  <= '0;
            r_door <= 1'b0;
            if (w_ahead) begin
              r_state  <= ST_MOVE;
              r_moving <= 1'b1;
            end else if (w_behind) begin
              r_state  <= ST_MOVE;
              r_moving <= 1'b1;
              r_dir    <= ~r_dir;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cur_floor = r_floor;
  assign dir       = r_dir;
  assign moving    = r_moving;
  assign door_open = r_door;
  assign arrived   = r_arrived;

endmodule

// File: tb/tb_elev_scheduler.sv
// tb_elev_scheduler: directed scenarios plus random requests, every cycle
// compared against a floor/array model of the car inside the bench.
module tb_elev_scheduler;

  localparam int NF  = 8;
  localparam int TRV = 4;
  localparam int DRC = 8;
  localparam int IDT = 64;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_floor;
  logic [1:0] req_type;
  logic [2:0] cur_floor;
  logic       dir, moving, door_open, arrived;
  logic [7:0] pend_in, pend_up, pend_down;

  int n_checks = 0;
  int n_err    = 0;

  elev_scheduler #(
    .NUM_FLOORS    (NF),
    .TRAVEL_CYCLES (TRV),
    .DOOR_CYCLES   (DRC),
    .IDLE_TIMEOUT  (IDT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_type  (req_type),
    .cur_floor (cur_floor),
    .dir       (dir),
    .moving    (moving),
    .door_open (door_open),
    .arrived   (arrived),
    .pend_in   (pend_in),
    .pend_up   (pend_up),
    .pend_down (pend_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 travelling, 2 door open
  int  m_mode;
  int  m_floor;
  bit  m_dir;
  int  m_timer;
  bit  m_arr;
  bit  m_live = 1'b0;
  bit  m_in[NF], m_up[NF], m_down[NF];
`ifdef IDLE_RETURN_EN
  int  m_idle;
`endif

  function automatic bit pend_at(input int f);
    return m_in[f] | m_up[f] | m_down[f];
  endfunction

  function automatic bit beyond(input int f, input bit d);
    for (int g = 0; g < NF; g++)
      if (pend_at(g) && (d ? (g > f) : (g < f)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_pend();
    for (int g = 0; g < NF; g++)
      if (pend_at(g)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit serves(input int f);
    bit same, opp;
    same = m_dir ? m_up[f] : m_down[f];
    opp  = m_dir ? m_down[f] : m_up[f];
    return m_in[f] | same | (opp & !beyond(f, m_dir));
  endfunction

  function automatic void arrive(input int f);
    bit ah;
    ah = beyond(f, m_dir);
    m_in[f] = 1'b0;
    if (m_dir) m_up[f] = 1'b0;
    else m_down[f] = 1'b0;
    if (!ah) begin
      if (m_dir) m_down[f] = 1'b0;
      else m_up[f] = 1'b0;
      m_dir = !m_dir;
    end
    m_mode  = 2;
    m_timer = 0;
    m_arr   = 1'b1;
  endfunction

  function automatic logic [31:0] mask(input int which);
    logic [31:0] v;
    v = '0;
    for (int g = 0; g < NF; g++)
      v[g] = (which == 0) ? m_in[g] : (which == 1) ? m_up[g] : m_down[g];
    return v;
  endfunction

  always @(posedge clk) begin
    bit ok, reopen;
    int f, t;
`ifdef IDLE_RETURN_EN
    bit idle_q;
`endif
    m_arr = 1'b0;
    if (reset) begin
      m_live  = 1'b1;
      m_mode  = 0;
      m_floor = 0;
      m_dir   = 1'b1;
      m_timer = 0;
      for (int g = 0; g < NF; g++) begin
        m_in[g] = 0; m_up[g] = 0; m_down[g] = 0;
      end
`ifdef IDLE_RETURN_EN
      m_idle = 0;
`endif
    end else begin
      f  = int'(req_floor);
      t  = int'(req_type);
      ok = req_valid && f < NF && t != 3
           && !(t == 1 && f == NF - 1) && !(t == 2 && f == 0);
      reopen = 1'b0;
`ifdef IDLE_RETURN_EN
      idle_q = (m_mode == 0) && !any_pend() && m_floor != 0 && !req_valid;
`endif
      case (m_mode)
        0: begin
          if (pend_at(m_floor)) arrive(m_floor);
          else if (any_pend()) begin
            if (!beyond(m_floor, m_dir)) m_dir = !m_dir;
            m_mode  = 1;
            m_timer = 0;
          end
        end
        1: begin
          m_timer++;
          if (m_timer == TRV) begin
            m_floor = m_dir ? m_floor + 1 : m_floor - 1;
            m_timer = 0;
            if (serves(m_floor)) arrive(m_floor);
          end
        end
        default: begin
          reopen = ok && f == m_floor
                   && (t == 0 || (t == 1 && m_dir) || (t == 2 && !m_dir)
                       || !beyond(m_floor, m_dir));
          if (reopen) m_timer = 0;
          else begin
            m_timer++;
            if (m_timer == DRC) begin
              m_timer = 0;
              if (beyond(m_floor, m_dir)) m_mode = 1;
              else if (beyond(m_floor, !m_dir)) begin
                m_dir  = !m_dir;
                m_mode = 1;
              end else m_mode = 0;
            end
          end
        end
      endcase
`ifdef IDLE_RETURN_EN
      if (idle_q) begin
        m_idle++;
        if (m_idle == IDT) begin
          m_in[0] = 1'b1;
          m_idle  = 0;
        end
      end else m_idle = 0;
`endif
      if (ok && !reopen) begin
        if (t == 0) m_in[f] = 1'b1;
        else if (t == 1) m_up[f] = 1'b1;
        else m_down[f] = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("cur_floor", cur_floor, m_floor);
      chk("dir", dir, m_dir);
      chk("moving", moving, m_mode == 1);
      chk("door_open", door_open, m_mode == 2);
      chk("arrived", arrived, m_arr);
      chk("pend_in", pend_in, mask(0));
      chk("pend_up", pend_up, mask(1));
      chk("pend_down", pend_down, mask(2));
      chk("move_door_excl", moving & door_open, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int f, input int t);
    req_valid = 1'b1;
    req_floor = 3'(f);
    req_type  = 2'(t);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_arrival(input string nm);
    int n;
    n = 0;
    while (arrived !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no arrived pulse within 300 cycles", nm);
    end
  endtask

  task automatic wait_floor(input string nm, input int fl);
    int n;
    n = 0;
    while (cur_floor !== 3'(fl) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: floor %0d not reached, at %0d", nm, fl, cur_floor);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, arrs;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_floor = '0;
    req_type  = '0;
    repeat (3) @(negedge clk);

    chk("rst_floor", cur_floor, 0);
    chk("rst_dir", dir, 1);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_arrived", arrived, 0);
    chk("rst_pend", {pend_in, pend_up, pend_down}, 0);
    reset = 1'b0;

    // inside request to floor 3 from reset
    send(3, 0);
    chk("r29_pend", pend_in, 8'h08);
    @(negedge clk);
    chk("r29_moving", moving, 1);
    chk("r29_dir", dir, 1);
    repeat (4) @(negedge clk);
    chk("r29_f1", cur_floor, 1);
    repeat (4) @(negedge clk);
    chk("r29_f2", cur_floor, 2);
    repeat (4) @(negedge clk);
    chk("r29_f3", cur_floor, 3);
    chk("r29_arrived", arrived, 1);
    chk("r29_door", door_open, 1);
    @(negedge clk);
    chk("r29_arr_once", arrived, 0);
    repeat (6) @(negedge clk);
    chk("r29_door_last", door_open, 1);
    @(negedge clk);
    chk("r29_door_shut", door_open, 0);
    chk("r29_idle", moving, 0);
    chk("r29_pend_clr", pend_in, 0);

    // dropped requests
    send(7, 1);
    send(0, 2);
    send(7, 3);
    chk("r32_pend", {pend_in, pend_up, pend_down}, 0);
    chk("r32_idle", {moving, door_open}, 0);

    // door reopen at floor 4 going up
    send(4, 0);
    send(6, 1);
    wait_arrival("r31_arrive");
    chk("r31_floor", cur_floor, 4);
    chk("r31_dir", dir, 1);
    arrs = 1;
    repeat (5) begin
      @(negedge clk);
      if (arrived) arrs++;
    end
    send(4, 0);
    chk("r31_pend_in4", pend_in[4], 0);
    n = 0;
    while (door_open && n < 30) begin
      n++;
      if (arrived) arrs++;
      @(negedge clk);
    end
    chk("r31_door_len", n, 8);
    chk("r31_arrivals", arrs, 1);
    repeat (30) @(negedge clk);

    // reset mid-move between floors 2 and 3
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(5, 0);
    wait_floor("r33_f2", 2);
    @(negedge clk);
    chk("r33_moving_pre", moving, 1);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_floor = 3'd6;
    req_type  = 2'd0;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    chk("r33_floor", cur_floor, 0);
    chk("r33_moving", moving, 0);
    chk("r33_pend", {pend_in, pend_up, pend_down}, 0);
    @(negedge clk);
    chk("r24_dropped", pend_in, 0);

    // hall-down 5, then hall-up 2 while passing floor 1
    send(5, 2);
    wait_floor("r30_f1", 1);
    send(2, 1);
    wait_arrival("r30_arr2");
    chk("r30_stop2", cur_floor, 2);
    @(negedge clk);
    wait_arrival("r30_arr5");
    chk("r30_stop5", cur_floor, 5);
    chk("r30_dir", dir, 0);
    chk("r30_pdown5", pend_down[5], 0);

`ifdef IDLE_RETURN_EN
    n = 0;
    while (door_open && n < 30) begin
      n++;
      @(negedge clk);
    end
    repeat (63) @(negedge clk);
    chk("r34_not_yet", pend_in, 0);
    @(negedge clk);
    chk("r34_home_req", pend_in, 8'h01);
    wait_arrival("r34_arrive");
    chk("r34_floor0", cur_floor, 0);
`endif

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(899, 0) == 0) reset = 1'b1;
      else reset = 1'b0;
      if ($urandom_range(5, 0) == 0) begin
        req_valid = 1'b1;
        req_floor = 3'($urandom_range(7, 0));
        req_type  = 2'($urandom_range(3, 0));
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
